// File: rtl/spi_pkg.sv
// Shared SPI definitions used by the slave and the SPI master.
package spi_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} spi_state_e;
  localparam int SPI_WIDTH_DEFAULT = 8;
endpackage

// File: rtl/spi_slave_param_if.sv
// SPI pins plus the fabric-side handshake of the parametrised SPI slave.
interface spi_slave_param_if
  import spi_pkg::*;
#(parameter int WIDTH = SPI_WIDTH_DEFAULT);
  logic             ss;
  logic             mosi;
  logic             miso;
  logic             en;
  logic [WIDTH-1:0] tx_data;
  logic             tx_load;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ack;
  logic             clr_flags;
  logic             overrun;
  logic             underrun;
  logic             busy;
  logic             irq;

  modport slave (
    input  ss, mosi, en, tx_data, tx_load, rx_ack, clr_flags,
    output miso, tx_ready, rx_data, rx_valid, overrun, underrun, busy, irq
  );

  modport master (
    output ss, mosi, en, tx_data, tx_load, rx_ack, clr_flags,
    input  miso, tx_ready, rx_data, rx_valid, overrun, underrun, busy, irq
  );
endinterface

// File: rtl/spi_slave_shifter.sv
// RX/TX shift register pair with selectable bit order; clear > load > shift.
module spi_slave_shifter #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mosi,
  output logic             tx_bit,
  output logic [WIDTH-1:0] rx_next
);
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_q, rx_d;

  assign tx_bit  = MSB_FIRST ? tx_q[WIDTH-1] : tx_q[0];
  assign rx_next = MSB_FIRST ? {rx_q[WIDTH-2:0], mosi} : {mosi, rx_q[WIDTH-1:1]};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    tx_d = tx_q;
    rx_d = rx_q;
    if (clear) begin
      tx_d = '0;
      rx_d = '0;
    end else if (load) begin
      tx_d = load_val;
      rx_d = '0;
    end else if (shift) begin
      tx_d = MSB_FIRST ? (tx_q << 1) : (tx_q >> 1);
      rx_d = rx_next;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q <= '0;
      rx_q <= '0;
    end else begin
      tx_q <= tx_d;
      rx_q <= rx_d;
    end
  end
endmodule

// File: rtl/spi_slave_param.sv
// SPI slave clocked by sck: framing FSM, bit counter, TX hold / RX handshakes and sticky flags.
module spi_slave_param
  import spi_pkg::*;
#(
  parameter int WIDTH     = SPI_WIDTH_DEFAULT,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                      sck,
  input logic                      rst,
  spi_slave_param_if.slave         bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  spi_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             overrun_q, overrun_d;
  logic             underrun_q, underrun_d;

  logic             sh_clear, sh_load, sh_shift, start_word, tx_bit;
  logic [WIDTH-1:0] sh_load_val, rx_next;

  spi_slave_shifter #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_shifter (
    .clk      (sck),
    .rst      (rst),
    .clear    (sh_clear),
    .load     (sh_load),
    .shift    (sh_shift),
    .load_val (sh_load_val),
    .mosi     (bus.mosi),
    .tx_bit   (tx_bit),
    .rx_next  (rx_next)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    underrun_d  = underrun_q;
    sh_clear    = 1'b0;
    sh_load     = 1'b0;
    sh_shift    = 1'b0;
    start_word  = 1'b0;
    sh_load_val = hold_full_q ? hold_q : '0;

    if (bus.tx_load && !hold_full_q) begin
      hold_d      = bus.tx_data;
      hold_full_d = 1'b1;
    end
    if (bus.rx_ack)    rx_valid_d = 1'b0;
    if (bus.clr_flags) begin
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (!bus.ss && bus.en) begin
          state_d    = ST_RUN;
          cnt_d      = '0;
          start_word = 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.ss) begin
          // Abort: partial word is dropped, the holding register is untouched.
          state_d  = ST_IDLE;
          cnt_d    = '0;
          sh_clear = 1'b1;
        end else begin
          sh_shift = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !bus.rx_ack) overrun_d = 1'b1;
            cnt_d = '0;
            if (bus.en) start_word = 1'b1;
            else        state_d    = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Word start (setup edge or burst reload) consumes the hold or flags an underrun.
    if (start_word) begin
      sh_load = 1'b1;
      if (hold_full_q) hold_full_d = 1'b0;
      else             underrun_d  = 1'b1;
    end
  end

  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
    end
  end

  assign bus.busy     = (state_q == ST_RUN);
  assign bus.miso     = bus.busy ? tx_bit : 1'b0;
  assign bus.tx_ready = !hold_full_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.overrun  = overrun_q;
  assign bus.underrun = underrun_q;
  assign bus.irq      = rx_valid_q | overrun_q | underrun_q;
endmodule
